// File: rtl/led_frame_buffer_if.sv
// Write-command channel into the LED frame buffer: valid/ready handshake plus
// the pixel command fields and the out-of-range error pulse.
interface led_frame_buffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_mode;
   logic [2:0] wr_row;
   logic [2:0] wr_col;
   logic       wr_data;
   logic       wr_err;

   modport master (
      output wr_valid, wr_mode, wr_row, wr_col, wr_data,
      input  wr_ready, wr_err
   );

   modport slave (
      input  wr_valid, wr_mode, wr_row, wr_col, wr_data,
      output wr_ready, wr_err
   );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store for the LED matrix scanner: drawing goes to the
// back buffer, and the front/back exchange waits for a scan frame boundary.
module led_frame_buffer #(
   parameter int ROWS            = 6,
   parameter int COLS            = 6,
   parameter bit ACTIVE_LOW_COLS = 1'b1,
   parameter bit COPY_ON_SWAP    = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   led_frame_buffer_if.slave   wr,
   input  logic                swap_req,
   output logic                swap_pending,
   output logic                swap_done,
   input  logic                frame_start,
   input  logic [2:0]          rd_row,
   output logic [COLS-1:0]     rd_cols
);

   localparam logic [COLS-1:0] OFF_PATTERN = ACTIVE_LOW_COLS ? {COLS{1'b1}} : {COLS{1'b0}};
   localparam logic [3:0]      ROWS_W      = 4'(ROWS);
   localparam logic [3:0]      COLS_W      = 4'(COLS);
   localparam logic [2:0]      LAST_ROW    = 3'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      COPY
   } state_t;

   logic [ROWS-1:0][COLS-1:0] frame_mem [2];
   state_t                    state;
   logic                      front_sel;
   logic                      back_sel;
   logic [2:0]                row_cnt;
   logic                      fill_val;
   logic                      wr_accept;
   logic                      pixel_in_range;
   logic                      swap_exec;
   logic                      rd_in_range;

   assign back_sel       = ~front_sel;
   // A swap about to execute takes priority over a write in the same cycle.
   assign wr.wr_ready    = (state == IDLE) && !(swap_pending && frame_start);
   assign wr_accept      = wr.wr_valid && wr.wr_ready;
   assign swap_exec      = frame_start && swap_pending && (state == IDLE);
   assign pixel_in_range = ({1'b0, wr.wr_row} < ROWS_W) && ({1'b0, wr.wr_col} < COLS_W);
   assign rd_in_range    = ({1'b0, rd_row} < ROWS_W);

   // NOTE: all state here is updated with non-blocking assignments so every
   // read in this block sees the pre-edge value, e.g. COPY reads the new front
   // through front_sel only from the cycle after the swap.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the buffers are plain flops, not a RAM macro, so they can and
         // must be cleared by reset.
         frame_mem[0] <= '0;
         frame_mem[1] <= '0;
         front_sel    <= 1'b0;
         state        <= IDLE;
         row_cnt      <= '0;
         fill_val     <= 1'b0;
         swap_pending <= 1'b0;
         swap_done    <= 1'b0;
         wr.wr_err    <= 1'b0;
         rd_cols      <= OFF_PATTERN;
      end else begin
         swap_done <= swap_exec;
         wr.wr_err <= 1'b0;
         rd_cols   <= rd_in_range ? (frame_mem[front_sel][rd_row] ^ OFF_PATTERN) : OFF_PATTERN;

         if (swap_exec) begin
            swap_pending <= swap_req;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (swap_exec) begin
                  front_sel <= ~front_sel;
                  if (COPY_ON_SWAP) begin
                     state   <= COPY;
                     row_cnt <= '0;
                  end
               end else if (wr_accept) begin
                  if (!wr.wr_mode[1]) begin
                     if (pixel_in_range) begin
                        frame_mem[back_sel][wr.wr_row][wr.wr_col] <= wr.wr_mode[0]
                           ? ~frame_mem[back_sel][wr.wr_row][wr.wr_col]
                           : wr.wr_data;
                     end else begin
                        wr.wr_err <= 1'b1;
                     end
                  end else begin
                     state    <= FILL;
                     row_cnt  <= '0;
                     fill_val <= wr.wr_mode[0];
                  end
               end
            end

            FILL: begin
               frame_mem[back_sel][row_cnt] <= {COLS{fill_val}};
               if (row_cnt == LAST_ROW) begin
                  state <= IDLE;
               end else begin
                  row_cnt <= row_cnt + 3'd1;
               end
            end

            COPY: begin
               frame_mem[back_sel][row_cnt] <= frame_mem[front_sel][row_cnt];
               if (row_cnt == LAST_ROW) begin
                  state <= IDLE;
               end else begin
                  row_cnt <= row_cnt + 3'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: a picture-level model predicts each
// cycle's outputs into a queue that an independent monitor drains and checks.
module tb_led_frame_buffer;

   localparam int ROWS = 6;
   localparam int COLS = 6;
   localparam logic [COLS-1:0] OFF = 6'b111111;

   typedef struct {
      logic       rst;
      logic       wr_valid;
      logic [1:0] mode;
      logic [2:0] row;
      logic [2:0] col;
      logic       data;
      logic       swap_req;
      logic       frame_start;
      logic [2:0] rd_row;
   } stim_t;

   typedef struct {
      bit              ready_chk;
      logic            ready;
      logic [COLS-1:0] cols;
      logic            done;
      logic            err;
      logic            pend;
      bit              lit_v;
      logic [COLS-1:0] lit;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic swap_req, swap_pending, swap_done, frame_start;
   logic [2:0] rd_row;
   logic [COLS-1:0] rd_cols;

   led_frame_buffer_if wr_if ();

   led_frame_buffer #(
      .ROWS(ROWS), .COLS(COLS), .ACTIVE_LOW_COLS(1'b1), .COPY_ON_SWAP(1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr_if),
      .swap_req     (swap_req),
      .swap_pending (swap_pending),
      .swap_done    (swap_done),
      .frame_start  (frame_start),
      .rd_row       (rd_row),
      .rd_cols      (rd_cols)
   );

   always #5 clk = ~clk;

   // Reference model: two images, which one is shown, a pending flag and how
   // many more cycles the buffer stays busy after a fill or a swap.
   bit m_img [2][ROWS][COLS];
   bit m_front;
   bit m_pend;
   int m_busy;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic stim_t idle_s();
      stim_t s;
      s = '{rst: 1'b0, wr_valid: 1'b0, mode: 2'b00, row: 3'd0, col: 3'd0,
            data: 1'b0, swap_req: 1'b0, frame_start: 1'b0, rd_row: 3'd0};
      return s;
   endfunction

   function automatic logic [COLS-1:0] shown_row(input int r);
      logic [COLS-1:0] p;
      for (int c = 0; c < COLS; c++) p[c] = ~m_img[m_front][r][c];
      return p;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and push what the outputs must look like.
   task automatic step(input stim_t s, output bit acc, input bit lit_v, input logic [COLS-1:0] lit);
      exp_t e;
      bit   ready, was_busy, swap, err;
      @(negedge clk);
      rst             = s.rst;
      wr_if.wr_valid  = s.wr_valid;
      wr_if.wr_mode   = s.mode;
      wr_if.wr_row    = s.row;
      wr_if.wr_col    = s.col;
      wr_if.wr_data   = s.data;
      swap_req        = s.swap_req;
      frame_start     = s.frame_start;
      rd_row          = s.rd_row;

      ready   = (m_busy == 0) && !(m_pend && s.frame_start);
      e.lit_v = lit_v;
      e.lit   = lit;
      e.ready = ready;
      e.cols  = (s.rd_row < ROWS) ? shown_row(int'(s.rd_row)) : OFF;
      acc     = 1'b0;
      if (s.rst) begin
         e.ready_chk = 1'b0;
         e.cols = OFF;
         e.done = 1'b0;
         e.err  = 1'b0;
         e.pend = 1'b0;
         m_img   = '{default: '{default: '{default: 1'b0}}};
         m_front = 1'b0;
         m_pend  = 1'b0;
         m_busy  = 0;
      end else begin
         e.ready_chk = 1'b1;
         acc      = s.wr_valid && ready;
         err      = 1'b0;
         was_busy = (m_busy > 0);
         swap     = s.frame_start && m_pend && !was_busy;
         if (was_busy) m_busy--;
         if (acc) begin
            if (s.mode == 2'b00 || s.mode == 2'b01) begin
               if (s.row < ROWS && s.col < COLS) begin
                  if (s.mode == 2'b00) m_img[!m_front][s.row][s.col] = s.data;
                  else                 m_img[!m_front][s.row][s.col] = !m_img[!m_front][s.row][s.col];
               end else begin
                  err = 1'b1;
               end
            end else begin
               for (int r = 0; r < ROWS; r++)
                  for (int c = 0; c < COLS; c++) m_img[!m_front][r][c] = s.mode[0];
               m_busy = ROWS;
            end
         end
         if (swap) begin
            m_front = !m_front;
            m_img[!m_front] = m_img[m_front];
            m_busy = ROWS;
            m_pend = s.swap_req;
         end else begin
            m_pend = m_pend | s.swap_req;
         end
         e.done = swap;
         e.err  = err;
         e.pend = m_pend;
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) step(idle_s(), acc, 1'b0, '0);
   endtask

   task automatic sweep(input bit lit_v, input logic [COLS-1:0] lit);
      stim_t s;
      bit    acc;
      s = idle_s();
      for (int r = 0; r < 8; r++) begin
         s.rd_row = 3'(r);
         step(s, acc, lit_v, lit);
      end
   endtask

   // Hold a write command until the model accepts it; pulses apply once.
   task automatic send(input stim_t s);
      bit acc;
      s.wr_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(s, acc, 1'b0, '0);
         if (acc) return;
         s.swap_req    = 1'b0;
         s.frame_start = 1'b0;
      end
      n_miss++;
      $display("FAIL send_timeout: write mode %0d not accepted within 20 cycles", s.mode);
   endtask

   task automatic pulse(input bit req, input bit fs);
      stim_t s;
      bit    acc;
      s = idle_s();
      s.swap_req    = req;
      s.frame_start = fs;
      step(s, acc, 1'b0, '0);
   endtask

   task automatic pixel(input logic [1:0] mode, input int r, input int c, input logic d);
      stim_t s;
      s = idle_s();
      s.mode = mode;
      s.row  = 3'(r);
      s.col  = 3'(c);
      s.data = d;
      send(s);
   endtask

   // Monitor: wr_ready is sampled mid-cycle, registered outputs after the edge.
   initial begin
      exp_t e;
      logic rdy_s;
      forever begin
         @(negedge clk);
         #2 rdy_s = wr_if.wr_ready;
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (e.ready_chk) check("wr_ready", {7'd0, rdy_s}, {7'd0, e.ready});
            check("rd_cols", {2'd0, rd_cols}, {2'd0, e.cols});
            check("swap_done", {7'd0, swap_done}, {7'd0, e.done});
            check("wr_err", {7'd0, wr_if.wr_err}, {7'd0, e.err});
            check("swap_pending", {7'd0, swap_pending}, {7'd0, e.pend});
            if (e.lit_v) check("rd_cols_literal", {2'd0, rd_cols}, {2'd0, e.lit});
         end
      end
   end

   initial begin
      stim_t s;
      bit    acc;
      rst = 1'b1;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_mode  = 2'b00;
      wr_if.wr_row   = 3'd0;
      wr_if.wr_col   = 3'd0;
      wr_if.wr_data  = 1'b0;
      swap_req       = 1'b0;
      frame_start    = 1'b0;
      rd_row         = 3'd0;

      s = idle_s();
      s.rst = 1'b1;
      step(s, acc, 1'b0, '0);
      step(s, acc, 1'b0, '0);
      sweep(1'b1, 6'b111111);

      // Single pixel, swap five cycles after the request, read it back.
      pixel(2'b00, 2, 3, 1'b1);
      pulse(1'b1, 1'b0);
      idle(4);
      pulse(1'b0, 1'b1);
      s = idle_s();
      s.rd_row = 3'd2;
      repeat (8) step(s, acc, 1'b1, 6'b110111);

      // Fill ones, toggle (0,0), swap.
      s = idle_s();
      s.mode = 2'b11;
      send(s);
      pixel(2'b01, 0, 0, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      idle(ROWS);
      s = idle_s();
      step(s, acc, 1'b1, 6'b000001);
      for (int r = 1; r < ROWS; r++) begin
         s.rd_row = 3'(r);
         step(s, acc, 1'b1, 6'b000000);
      end

      // Out-of-range writes leave the picture alone.
      pixel(2'b00, 6, 2, 1'b0);
      pixel(2'b01, 1, 7, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      idle(ROWS);
      sweep(1'b0, '0);

      // Swap requested during a fill; frame_start in fill cycle 3 is deferred.
      s = idle_s();
      s.mode = 2'b10;
      send(s);
      pulse(1'b1, 1'b0);
      idle(1);
      pulse(1'b0, 1'b1);
      idle(4);
      pulse(1'b0, 1'b1);
      idle(ROWS);
      sweep(1'b0, '0);

      // Write held off by a swap in the same cycle, lands after the copy.
      pulse(1'b1, 1'b0);
      s = idle_s();
      s.frame_start = 1'b1;
      s.row = 3'd4;
      s.col = 3'd5;
      s.data = 1'b1;
      send(s);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      idle(ROWS);
      sweep(1'b0, '0);

      // Reset in the middle of a copy.
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      idle(2);
      s = idle_s();
      s.rst = 1'b1;
      step(s, acc, 1'b0, '0);
      sweep(1'b1, 6'b111111);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         s.rst         = ($urandom_range(0, 399) == 0);
         s.wr_valid    = ($urandom_range(0, 1) == 1);
         s.mode        = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         s.row         = 3'($urandom_range(0, 7));
         s.col         = 3'($urandom_range(0, 7));
         s.data        = 1'($urandom_range(0, 1));
         s.swap_req    = ($urandom_range(0, 9) == 0);
         s.frame_start = ($urandom_range(0, 7) == 0);
         s.rd_row      = 3'($urandom_range(0, 7));
         step(s, acc, 1'b0, '0);
      end
      idle(1);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      #3;
      if (q.size() > 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/led_frame_buffer.md
Name: led_frame_buffer

Overview:
- Double-buffered 6x6 pixel store feeding the LED matrix row/column scanner.
- Upstream logic draws into a back buffer through a valid/ready write port. The scanner reads row patterns from the front buffer.
- A requested swap takes effect only at a scan frame boundary, so no frame shows a half-drawn image.
- Optional copy-on-swap seeds the new back buffer with the displayed image, which allows incremental drawing.

Parameters:
ROWS, 6, number of matrix rows (1..8)
COLS, 6, number of matrix columns (1..8)
ACTIVE_LOW_COLS, 1, 1 = rd_cols bit low means pixel lit (matches col drive); 0 = active-high
COPY_ON_SWAP, 1, 1 = after each swap copy new front into back (ROWS cycles); 0 = plain ping-pong

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write command valid
wr_ready  out  1  write command accepted when wr_valid && wr_ready
wr_mode  in  2  00 set pixel, 01 toggle pixel, 10 clear back buffer, 11 fill back buffer
wr_row  in  3  pixel row (modes 00/01)
wr_col  in  3  pixel column (modes 00/01)
wr_data  in  1  pixel value (mode 00)
wr_err  out  1  one-cycle pulse: accepted pixel write had row>=ROWS or col>=COLS (ignored)
swap_req  in  1  pulse: request front/back exchange
swap_pending  out  1  swap requested, not yet executed
swap_done  out  1  one-cycle pulse on cycle after swap executes
frame_start  in  1  pulse from scanner when row index wraps to 0
rd_row  in  3  row currently being scanned
rd_cols  out  COLS  column pattern of front buffer row rd_row

Behaviour:
- Storage: two ROWS x COLS bit arrays. front_sel selects the displayed one. The other is the back buffer.
- Reset (sync, rst=1 at clk edge):
  - both buffers all 0; front_sel=0; state IDLE; swap_pending=0; swap_done=0; wr_err=0.
  - rd_cols = all-off: all 1s if ACTIVE_LOW_COLS, else all 0s.
  - Reset during FILL/COPY aborts the operation immediately.
- FSM states: IDLE, FILL, COPY.
  - wr_ready = (state==IDLE) && !(swap_pending && frame_start). This is combinational.
- IDLE:
  - mode 00 writes wr_data to back[wr_row][wr_col]; mode 01 inverts that bit. Both complete in one cycle.
  - Out-of-range coordinates: command accepted, no storage change, wr_err=1 next cycle.
  - Modes 10/11: go to FILL with row counter 0, fill value 0/1. wr_row/wr_col/wr_data are ignored.
- FILL: writes one full back-buffer row per cycle. After row ROWS-1, returns to IDLE. Duration is ROWS cycles; wr_ready=0 throughout.
- Swap:
  - swap_req sets swap_pending. A repeated swap_req while pending has no extra effect.
  - Swap executes in a cycle where frame_start=1, swap_pending=1 and state==IDLE. That cycle: front_sel inverts, swap_pending clears, swap_done=1 on the next cycle.
  - A swap_req in the execute cycle re-arms swap_pending for the next frame.
  - frame_start while state is FILL/COPY: swap deferred to the next qualifying frame_start.
- COPY (COPY_ON_SWAP=1 only): entered on the cycle after a swap.
  - Copies new front row r into back row r, one row per cycle, ROWS cycles, then IDLE. wr_ready=0 throughout.
  - If COPY_ON_SWAP=0: stay IDLE; back buffer holds the previous front image.
- Read path:
  - rd_cols registered, latency 1: value at cycle t+1 reflects front[rd_row] at edge t, inverted if ACTIVE_LOW_COLS.
  - rd_row>=ROWS gives all-off.
  - A swap at edge t affects rd_cols from t+1 onward. The scanner never sees mixed buffers within a row read.
- rd_cols bit i corresponds to column i. The LSB is column 0, matching the one-hot column decode in the scanner.

Test Plan:
- Reset release, rd_row sweep 0..7: rd_cols=6'b111111 every cycle; wr_ready=1; swap_pending=0.
- Write set (2,3)=1, swap_req, frame_start 5 cycles later:
  - swap_pending=1 until frame_start; swap_done pulses one cycle after.
  - rd_row=2 then gives rd_cols=6'b110111.
  - with COPY_ON_SWAP=1, wr_ready=0 for exactly 6 cycles after the swap.
- Mode 11 fill then mode 01 toggle (0,0):
  - wr_ready low for 6 cycles during the fill.
  - after swap, row 0 reads 6'b000001; rows 1-5 read 6'b000000.
- Write (6,2) and (1,7):
  - both accepted; wr_err pulses once for each.
  - no storage change: all rows read unchanged after swap.
- swap_req during FILL, frame_start in cycle 3 of fill: no swap; next frame_start after IDLE executes it (single swap_done).
- swap_req and frame_start in the same cycle as wr_valid (pending already set):
  - wr_ready=0 that cycle; swap executes.
  - the held write is accepted after COPY completes and lands in the new back buffer.
- rst asserted mid-COPY: next cycle state IDLE, both buffers zero, rd_cols=6'b111111, swap_pending=0.
